aes_input_block_buffer: RTL and testbench

//  Packs 32-bit plaintext/ciphertext words from the AHB-lite slave write path into 128-bit AES blocks.

---
 rtl/aes_input_block_buffer.sv | 140 ++++++++++++++
 tb/tb_aes_input_block_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/aes_input_block_buffer.sv
// -----------------------------------------------------------------------------
// aes_input_block_buffer
//
// Packs 32-bit data words from the AHB-lite slave write path (data window
// 0x40-0x7C) into 128-bit AES blocks. Completed blocks are queued in a
// DEPTH-entry FIFO, and the FIFO head is offered to the AES round core over
// a valid/ready handshake.
//
// Build option:
//   AES_INBUF_BYTE_SWAP_EN - when defined, each incoming word is byte-reversed
//                            before packing, for little-endian masters. Ports
//                            and timing are the same with or without it.
//
// Ports:
//   HCLK       in   1      system clock, rising edge
//   HRESETn    in   1      asynchronous active-low reset
//   wr_en      in   1      wr_word is valid this cycle
//   wr_word    in   32     data word; the first word of a block is bits [127:96]
//   clear      in   1      synchronous flush of the assembly reg, FIFO and flags
//   blk_valid  out  1      FIFO head holds a block
//   blk_data   out  128    FIFO head block (show-ahead), 0 when empty
//   blk_ready  in   1      core accepts the head block this cycle
//   blk_count  out  CNT_W  number of queued blocks, 0..DEPTH
//   word_idx   out  2      words already held in the current partial block
//   full       out  1      blk_count == DEPTH
//   overflow   out  1      sticky: a completed block was dropped
// -----------------------------------------------------------------------------
module aes_input_block_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             wr_en,
  input  logic [31:0]      wr_word,
  input  logic             clear,
  output logic             blk_valid,
  output logic [127:0]     blk_data,
  input  logic             blk_ready,
  output logic [CNT_W-1:0] blk_count,
  output logic [1:0]       word_idx,
  output logic             full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      word_in;
  logic [127:0]     asm_q;
  logic [127:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       idx_q;
  logic             ovf_q;

  logic             take_word;
  logic             push_blk;
  logic             pop;
  logic             accept;
  logic             drop;
  logic [127:0]     new_blk;

`ifdef AES_INBUF_BYTE_SWAP_EN
  assign word_in = {wr_word[7:0], wr_word[15:8], wr_word[23:16], wr_word[31:24]};
`else
  assign word_in = wr_word;
`endif

  // Outputs come straight from registered state, so there is no
  // combinational path from wr_en to blk_valid.
  assign blk_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign blk_count = count_q;
  assign word_idx  = idx_q;
  assign overflow  = ovf_q;
  assign blk_data  = blk_valid ? fifo_mem[rd_ptr_q] : '0;

  // clear overrides both the write and the pop side.
  assign take_word = wr_en & ~clear;
  assign push_blk  = take_word & (idx_q == 2'd3);
  assign pop       = blk_valid & blk_ready & ~clear;
  // A pop on the same edge frees the slot, so a push into a full FIFO succeeds.
  assign accept    = push_blk & (~full | pop);
  assign drop      = push_blk & full & ~pop;
  assign new_blk   = {asm_q[127:32], word_in};

  // Block storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= new_blk;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      asm_q    <= '0;
      idx_q    <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      asm_q    <= '0;
      idx_q    <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (take_word) begin
        case (idx_q)
          2'd0:    asm_q[127:96] <= word_in;
          2'd1:    asm_q[95:64]  <= word_in;
          2'd2:    asm_q[63:32]  <= word_in;
          default: asm_q[31:0]   <= word_in;
        endcase
        idx_q <= idx_q + 2'd1;
      end

      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if (accept && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - CNT_W'(1);
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_input_block_buffer.sv
module tb_aes_input_block_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             tb_HCLK;
  logic             HRESETn;
  logic             wr_en;
  logic [31:0]      wr_word;
  logic             clear;
  logic             blk_valid;
  logic [127:0]     blk_data;
  logic             blk_ready;
  logic [CNT_W-1:0] blk_count;
  logic [1:0]       word_idx;
  logic             full;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  logic [127:0] sb [$];
  logic [31:0]  m_w [4];
  logic [1:0]   m_idx;
  logic         m_ovf;

  aes_input_block_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .HCLK      (tb_HCLK),
    .HRESETn   (HRESETn),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .clear     (clear),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .blk_count (blk_count),
    .word_idx  (word_idx),
    .full      (full),
    .overflow  (overflow)
  );

  initial begin
    tb_HCLK = 1'b0;
    forever #5 tb_HCLK = ~tb_HCLK;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] w);
`ifdef AES_INBUF_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_idx = 2'd0;
    m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_w[i] = '0;
  endtask

  // One clock cycle: check the head against the scoreboard, drive inputs,
  // advance the model, clock, then check the registered state.
  task automatic cyc(input logic we, input logic [31:0] w, input logic rdy, input logic clr);
    logic [127:0] blk;
    chk("valid", 128'(blk_valid), 128'(sb.size() != 0));
    if (sb.size() != 0) chk("head", blk_data, sb[0]);
    else chk("empty_data", blk_data, '0);
    wr_en = we; wr_word = w; blk_ready = rdy; clear = clr;
    if (clr) begin
      sb.delete();
      m_idx = 2'd0;
      m_ovf = 1'b0;
    end else begin
      if (rdy && sb.size() != 0) blk = sb.pop_front();
      if (we) begin
        m_w[m_idx] = mw(w);
        if (m_idx == 2'd3) begin
          blk = {m_w[0], m_w[1], m_w[2], m_w[3]};
          if (sb.size() < DEPTH) sb.push_back(blk);
          else m_ovf = 1'b1;
        end
        m_idx = m_idx + 2'd1;
      end
    end
    @(posedge tb_HCLK); #1;
    wr_en = 1'b0; blk_ready = 1'b0; clear = 1'b0;
    chk("count", 128'(blk_count), 128'(sb.size()));
    chk("word_idx", 128'(word_idx), 128'(m_idx));
    chk("full", 128'(full), 128'(sb.size() == DEPTH));
    chk("overflow", 128'(overflow), 128'(m_ovf));
  endtask

  task automatic put_blk(input logic [31:0] base, input logic rdy_last);
    for (int i = 0; i < 4; i++) cyc(1'b1, base + 32'(i), (i == 3) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && sb.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_done", 128'(sb.size()), 128'(0));
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    HRESETn = 1'b0; wr_en = 1'b0; wr_word = '0; clear = 1'b0; blk_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 128'(blk_valid), 128'(0));
    chk("rst_count", 128'(blk_count), 128'(0));
    chk("rst_data", blk_data, '0);
    chk("rst_full", 128'(full), 128'(0));
    HRESETn = 1'b1;
    @(posedge tb_HCLK); #1;

    // 1) single block
    cyc(1'b1, 32'h74686973, 1'b0, 1'b0);
    cyc(1'b1, 32'h69737468, 1'b0, 1'b0);
    cyc(1'b1, 32'h656b6579, 1'b0, 1'b0);
    cyc(1'b1, 32'h30303030, 1'b0, 1'b0);
`ifndef AES_INBUF_BYTE_SWAP_EN
    chk("t1_data", blk_data, 128'h74686973_69737468_656b6579_30303030);
`endif
    chk("t1_valid", 128'(blk_valid), 128'(1));
    drain();

    // 2) five blocks with no pops: E dropped
    for (int b = 0; b < 5; b++) put_blk(32'hA000_0000 + 32'(b << 8), 1'b0);
    chk("t2_full", 128'(full), 128'(1));
    chk("t2_ovf", 128'(overflow), 128'(1));
    drain();

    // 3) push into a full FIFO on the same edge as a pop
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) put_blk(32'hB000_0000 + 32'(b << 8), 1'b0);
    put_blk(32'hB000_0400, 1'b1);
    chk("t3_count", 128'(blk_count), 128'(DEPTH));
    chk("t3_ovf", 128'(overflow), 128'(0));
    drain();

    // 4) clear with a coincident write discards the partial block
    cyc(1'b1, 32'hDEAD0000, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD0001, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD0002, 1'b0, 1'b1);
    chk("t4_idx", 128'(word_idx), 128'(0));
    put_blk(32'hC0DE_0000, 1'b0);
    drain();

    // random mix of writes, pops and occasional clears
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 60) == 0));
    drain();

    // 5) asynchronous reset mid-cycle
    put_blk(32'hE000_0000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hE100_0000 + 32'(i), 1'b0, 1'b0);
    #2 HRESETn = 1'b0;
    #1;
    chk("t5_valid", 128'(blk_valid), 128'(0));
    chk("t5_count", 128'(blk_count), 128'(0));
    chk("t5_idx", 128'(word_idx), 128'(0));
    chk("t5_data", blk_data, '0);
    model_reset();
    #2 HRESETn = 1'b1;
    put_blk(32'hF000_0000, 1'b0);
    chk("t5_one", 128'(blk_count), 128'(1));
    drain();

    // 6) byte order of the first word
    cyc(1'b1, 32'h73696874, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, 1'b0, 1'b0);
`ifdef AES_INBUF_BYTE_SWAP_EN
    chk("t6_hi", 128'(blk_data[127:96]), 128'(32'h74686973));
`else
    chk("t6_hi", 128'(blk_data[127:96]), 128'(32'h73696874));
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
